// File: rtl/touch_key_scheduler_pkg.sv
// rtl/touch_key_scheduler_pkg.sv - key codes, touch region bounds and press FSM encoding
package touch_key_scheduler_pkg;

  localparam logic [3:0] KEY_NONE     = 4'd0;
  localparam logic [3:0] KEY_PROD_1   = 4'd1;
  localparam logic [3:0] KEY_PROD_8   = 4'd8;
  localparam logic [3:0] KEY_CONFIRM  = 4'd9;
  localparam logic [3:0] KEY_CANCEL   = 4'd10;
  localparam logic [3:0] KEY_COIN_1J  = 4'd11;
  localparam logic [3:0] KEY_COIN_5J  = 4'd12;
  localparam logic [3:0] KEY_COIN_5Y  = 4'd13;
  localparam logic [3:0] KEY_COIN_10Y = 4'd14;

  localparam int          PROD_COLS     = 4;
  localparam logic [15:0] PROD_X_LO     = 16'd40;
  localparam logic [15:0] PROD_X_PITCH  = 16'd80;
  localparam logic [15:0] ROW0_Y_LO     = 16'd40;
  localparam logic [15:0] ROW0_Y_HI     = 16'd119;
  localparam logic [15:0] ROW1_Y_LO     = 16'd120;
  localparam logic [15:0] ROW1_Y_HI     = 16'd199;
  localparam logic [15:0] CONFIRM_X_LO  = 16'd40;
  localparam logic [15:0] CONFIRM_X_HI  = 16'd199;
  localparam logic [15:0] CANCEL_X_LO   = 16'd200;
  localparam logic [15:0] CANCEL_X_HI   = 16'd359;
  localparam logic [15:0] CMD_Y_LO      = 16'd380;
  localparam logic [15:0] CMD_Y_HI      = 16'd419;
  localparam logic [15:0] COIN_X_LO     = 16'd420;
  localparam logic [15:0] COIN_X_HI     = 16'd499;
  localparam logic [15:0] COIN_1J_Y_LO  = 16'd375;
  localparam logic [15:0] COIN_1J_Y_HI  = 16'd394;
  localparam logic [15:0] COIN_5J_Y_LO  = 16'd395;
  localparam logic [15:0] COIN_5J_Y_HI  = 16'd414;
  localparam logic [15:0] COIN_5Y_Y_LO  = 16'd415;
  localparam logic [15:0] COIN_5Y_Y_HI  = 16'd434;
  localparam logic [15:0] COIN_10Y_Y_LO = 16'd435;
  localparam logic [15:0] COIN_10Y_Y_HI = 16'd454;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_REL_DB
  } press_state_t;

  function automatic logic in_range(input logic [15:0] v, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Product column hit as 1..PROD_COLS, or 0 when X is outside every column.
  function automatic logic [2:0] prod_col(input logic [15:0] x);
    logic [2:0] col;
    col = 3'd0;
    for (int c = PROD_COLS - 1; c >= 0; c--) begin
      if (in_range(x, PROD_X_LO + 16'(c) * PROD_X_PITCH,
                   PROD_X_LO + 16'(c + 1) * PROD_X_PITCH - 16'd1))
        col = 3'(c + 1);
    end
    return col;
  endfunction

endpackage

// File: rtl/touch_key_scheduler_key_fifo.sv
// rtl/touch_key_scheduler_key_fifo.sv - first-word-fall-through key event queue
module key_fifo
  import touch_key_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [LW-1:0]    level,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign head_valid = (level != '0);
  assign full       = (level == LW'(DEPTH));
  assign do_pop     = pop_ready && head_valid;
  // A full queue still accepts a write when the head leaves on the same edge.
  assign do_push    = push && (!full || do_pop);
  assign drop       = push && full && !do_pop;
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/touch_key_scheduler.sv
// rtl/touch_key_scheduler.sv - touch coordinate decode, press debounce and key event queue
module touch_key_scheduler
  import touch_key_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        touch_valid,
  input  logic [31:0] data,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        busy,
  output logic [2:0]  fifo_level,
  output logic [7:0]  drop_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [15:0]  x;
  logic [15:0]  y;
  logic [2:0]   col;
  logic [3:0]   decoded;
  press_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0]   cand_key;
  logic         push;
  logic         drop;
  logic [LW-1:0] level;

  assign x   = data[31:16];
  assign y   = data[15:0];
  assign col = prod_col(x);

  always_comb begin
    decoded = KEY_NONE;
    if (col != 3'd0 && in_range(y, ROW0_Y_LO, ROW0_Y_HI))
      decoded = 4'(col);
    else if (col != 3'd0 && in_range(y, ROW1_Y_LO, ROW1_Y_HI))
      decoded = 4'(col) + 4'd4;
    else if (in_range(x, CONFIRM_X_LO, CONFIRM_X_HI) && in_range(y, CMD_Y_LO, CMD_Y_HI))
      decoded = KEY_CONFIRM;
    else if (in_range(x, CANCEL_X_LO, CANCEL_X_HI) && in_range(y, CMD_Y_LO, CMD_Y_HI))
      decoded = KEY_CANCEL;
    else if (in_range(x, COIN_X_LO, COIN_X_HI)) begin
      if (in_range(y, COIN_1J_Y_LO, COIN_1J_Y_HI))        decoded = KEY_COIN_1J;
      else if (in_range(y, COIN_5J_Y_LO, COIN_5J_Y_HI))   decoded = KEY_COIN_5J;
      else if (in_range(y, COIN_5Y_Y_LO, COIN_5Y_Y_HI))   decoded = KEY_COIN_5Y;
      else if (in_range(y, COIN_10Y_Y_LO, COIN_10Y_Y_HI)) decoded = KEY_COIN_10Y;
    end
  end

  // The push lands on the same edge the FSM enters HELD, so no extra latency.
  assign push = touch_valid && (decoded != KEY_NONE) &&
                ((state == ST_PRESS_DB && decoded == cand_key && cnt == CNT_LAST) ||
                 (state == ST_IDLE && DEBOUNCE_CYC <= 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cand_key <= KEY_NONE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (touch_valid) begin
            cand_key <= decoded;
            cnt      <= CW'(1);
            state    <= (DEBOUNCE_CYC <= 1) ? ST_HELD : ST_PRESS_DB;
          end
        end
        ST_PRESS_DB: begin
          if (!touch_valid) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (decoded != cand_key) begin
            cand_key <= decoded;
            cnt      <= CW'(1);
          end else if (cnt == CNT_LAST) begin
            cnt   <= cnt + CW'(1);
            state <= ST_HELD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HELD: begin
          if (!touch_valid) begin
            cnt   <= CW'(1);
            state <= (DEBOUNCE_CYC <= 1) ? ST_IDLE : ST_REL_DB;
          end
        end
        ST_REL_DB: begin
          if (touch_valid) begin
            state <= ST_HELD;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= 8'd0;
    else if (drop && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end

  key_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(4),
    .LW   (LW)
  ) u_key_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cand_key),
    .pop_ready (key_ready),
    .head_data (key_code),
    .head_valid(key_valid),
    .level     (level),
    .drop      (drop)
  );

  assign busy       = (state != ST_IDLE);
  assign fifo_level = 3'(level);

endmodule

// File: tb/tb_touch_key_scheduler.sv
// tb/tb_touch_key_scheduler.sv - directed self-checking bench for touch_key_scheduler
module tb_touch_key_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        touch_valid;
  logic [31:0] data;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  touch_key_scheduler #(.DEBOUNCE_CYC(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .touch_valid(touch_valid),
    .data       (data),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_key(input logic [31:0] d);
    data = d;
    touch_valid = 1'b1;
    tick(5);
    touch_valid = 1'b0;
    tick(5);
  endtask

  task automatic pop_check(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, key_code}, {28'd0, exp});
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    touch_valid = 1'b0;
    data = 32'd0;
    key_ready = 1'b0;
    tick(2);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    tick(1);

    // single press, consumer always ready
    key_ready = 1'b1;
    data = 32'h0064_0064;
    touch_valid = 1'b1;
    tick(3);
    check("lat_early_valid", {31'd0, key_valid}, 32'd0);
    check("lat_busy", {31'd0, busy}, 32'd1);
    tick(1);
    check("lat_valid", {31'd0, key_valid}, 32'd1);
    check("lat_code", {28'd0, key_code}, 32'd1);
    tick(1);
    check("one_cycle_valid", {31'd0, key_valid}, 32'd0);
    touch_valid = 1'b0;
    tick(4);
    check("release_busy", {31'd0, busy}, 32'd0);
    key_ready = 1'b0;

    // two coin presses queued
    press_key(32'h01C2_0190);
    press_key(32'h01C2_01A9);
    check("coin_level", {29'd0, fifo_level}, 32'd2);
    pop_check("coin_pop0", 4'd12);
    pop_check("coin_pop1", 4'd13);
    check("coin_empty", {31'd0, key_valid}, 32'd0);

    // bounce rejection
    touch_valid = 1'b1; tick(1);
    touch_valid = 1'b0; tick(1);
    touch_valid = 1'b1; tick(1);
    touch_valid = 1'b0; tick(1);
    check("bounce_busy", {31'd0, busy}, 32'd0);
    check("bounce_level", {29'd0, fifo_level}, 32'd0);
    data = 32'h0064_0064; touch_valid = 1'b1; tick(2);
    data = 32'h0064_0190; tick(3);
    touch_valid = 1'b0; tick(1);
    check("moving_level", {29'd0, fifo_level}, 32'd0);
    touch_valid = 1'b1; tick(4);
    check("stable_valid", {31'd0, key_valid}, 32'd1);
    check("stable_code", {28'd0, key_code}, 32'd9);
    touch_valid = 1'b0; tick(4);
    pop_check("stable_pop", 4'd9);
    check("stable_empty", {29'd0, fifo_level}, 32'd0);

    // overflow: six confirms into depth 4
    for (int i = 0; i < 6; i++)
      press_key(32'h0064_0190);
    check("ovf_level", {29'd0, fifo_level}, 32'd4);
    check("ovf_drop", {24'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 4; i++)
      pop_check("ovf_pop", 4'd9);
    check("ovf_empty_valid", {31'd0, key_valid}, 32'd0);
    check("ovf_empty_code", {28'd0, key_code}, 32'd0);
    key_ready = 1'b1; tick(1); key_ready = 1'b0;
    check("ready_when_empty", {29'd0, fifo_level}, 32'd0);

    // decode coverage and region boundaries
    press_key(32'h00A0_0064);
    press_key(32'h0140_00A0);
    press_key(32'h00FA_0190);
    press_key(32'h0077_0077);
    check("dec_level_a", {29'd0, fifo_level}, 32'd4);
    pop_check("dec_key2", 4'd2);
    pop_check("dec_key8", 4'd8);
    pop_check("dec_cancel", 4'd10);
    pop_check("dec_edge_hi", 4'd1);
    press_key(32'h0078_0078);
    press_key(32'h01C2_0181);
    press_key(32'h01C2_01B8);
    press_key(32'h0027_0064);
    check("dec_level_b", {29'd0, fifo_level}, 32'd3);
    pop_check("dec_edge_lo", 4'd6);
    pop_check("dec_coin1j", 4'd11);
    pop_check("dec_coin10y", 4'd14);
    check("dec_drop", {24'd0, drop_cnt}, 32'd2);

    // no-key press still walks through HELD
    data = 32'h0000_0000; touch_valid = 1'b1; tick(4);
    check("none_held_busy", {31'd0, busy}, 32'd1);
    tick(6);
    check("none_level", {29'd0, fifo_level}, 32'd0);
    touch_valid = 1'b0; tick(4);
    check("none_idle", {31'd0, busy}, 32'd0);

    // release glitch while HELD
    data = 32'h0064_0064; touch_valid = 1'b1; tick(5);
    touch_valid = 1'b0; tick(1);
    touch_valid = 1'b1; tick(5);
    touch_valid = 1'b0; tick(5);
    check("glitch_level", {29'd0, fifo_level}, 32'd1);

    // async reset mid-press with three queued
    press_key(32'h0064_0064);
    press_key(32'h0064_0064);
    check("pre_rst_level", {29'd0, fifo_level}, 32'd3);
    data = 32'h00A0_0064; touch_valid = 1'b1; tick(2);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, key_valid}, 32'd0);
    check("arst_code", {28'd0, key_code}, 32'd0);
    check("arst_level", {29'd0, fifo_level}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(3);
    check("post_rst_early", {29'd0, fifo_level}, 32'd0);
    tick(1);
    check("post_rst_level", {29'd0, fifo_level}, 32'd1);
    check("post_rst_code", {28'd0, key_code}, 32'd2);
    tick(3);
    touch_valid = 1'b0; tick(5);
    check("post_rst_once", {29'd0, fifo_level}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
